// File: rtl/sdspi_arbiter.sv
// Round-robin arbiter sharing one SD-SPI core between NUM_REQ requesters.
// Optional owner watchdog enabled by defining SDSPI_ARB_TIMEOUT_EN.
module sdspi_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  input  logic [NUM_REQ-1:0]     req_r_multi_block_i,
  input  logic [NUM_REQ-1:0]     req_r_byte_i,
  input  logic [32*NUM_REQ-1:0]  req_block_addr_i,
  input  logic [5*NUM_REQ-1:0]   req_sclk_speed_i,
  output logic [NUM_REQ-1:0]     req_busy_o,
  output logic [NUM_REQ-1:0]     req_err_o,
  output logic [7:0]             req_dat_o,
  output logic                   timeout_o,
  output logic                   spi_rst,
  output logic                   spi_r_multi_block,
  output logic                   spi_r_byte,
  output logic [31:0]            spi_block_addr,
  output logic [4:0]             spi_sclk_speed,
  input  logic                   spi_busy,
  input  logic                   spi_err,
  input  logic [7:0]             spi_dat_o
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_IDLE      = 3'd2,
    ST_OWNED     = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [IW-1:0]      last_reg, last_next;
  logic               drain_first_reg, drain_first_next;
  logic               err_seen_reg, err_seen_next;
  logic               spi_rst_reg;
  logic [31:0]        addr_reg;
  logic [4:0]         speed_reg;

  logic [31:0]        addr_slice [NUM_REQ];
  logic [4:0]         speed_slice [NUM_REQ];
  logic [31:0]        owner_addr;
  logic [4:0]         owner_speed;
  logic               owner_req, owner_mb, owner_byte;
  logic               in_owned;

  logic [NUM_REQ-1:0] mask_reg;
  logic               to_hit;
  logic [NUM_REQ-1:0] eligible;
  logic               arb_found;
  logic [IW-1:0]      arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_slice[gi]  = req_block_addr_i[32*gi +: 32];
      assign speed_slice[gi] = req_sclk_speed_i[5*gi +: 5];
      assign req_busy_o[gi]  = gnt_reg[gi] ? spi_busy : 1'b1;
      assign req_err_o[gi]   = gnt_reg[gi] & spi_err;
    end
  endgenerate

  // gnt_reg is non-zero only while OWNED, so it doubles as the owner select.
  always_comb begin
    owner_addr  = '0;
    owner_speed = '0;
    owner_req   = 1'b0;
    owner_mb    = 1'b0;
    owner_byte  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_reg[i]) begin
        owner_addr  = addr_slice[i];
        owner_speed = speed_slice[i];
        owner_req   = req_i[i];
        owner_mb    = req_r_multi_block_i[i];
        owner_byte  = req_r_byte_i[i];
      end
    end
  end

  assign in_owned          = (state_reg == ST_OWNED);
  assign spi_r_multi_block = in_owned & owner_mb;
  assign spi_r_byte        = in_owned & owner_byte;
  assign spi_block_addr    = in_owned ? owner_addr : addr_reg;
  assign spi_sclk_speed    = in_owned ? owner_speed : speed_reg;
  assign gnt_o             = gnt_reg;
  assign spi_rst           = spi_rst_reg;
  assign req_dat_o         = spi_dat_o;

`ifdef SDSPI_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_reg;
  logic        timeout_reg;
  logic        to_evict;

  assign to_hit    = (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1)) && !owner_byte;
  assign to_evict  = in_owned && owner_req && to_hit;
  assign timeout_o = timeout_reg;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
      mask_reg    <= '0;
    end else begin
      timeout_reg <= to_evict;
      if (state_reg == ST_IDLE && arb_found)
        to_cnt_reg <= '0;
      else if (in_owned)
        to_cnt_reg <= owner_byte ? 32'd0 : to_cnt_reg + 32'd1;
      // An evicted requester stays out of arbitration until it lets go once.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_i[i])
          mask_reg[i] <= 1'b0;
        else if (to_evict && gnt_reg[i])
          mask_reg[i] <= 1'b1;
      end
    end
  end
`else
  assign to_hit    = 1'b0;
  assign mask_reg  = '0;
  assign timeout_o = 1'b0;
`endif

  assign eligible = req_i & ~mask_reg;

  always_comb begin
    int cand;
    logic [IW-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = last_reg;
    cand      = 0;
    cand_idx  = '0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      cand     = (int'(last_reg) + j) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!arb_found && eligible[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    last_next        = last_reg;
    drain_first_next = drain_first_reg;
    err_seen_next    = err_seen_reg;
    case (state_reg)
      ST_INIT: begin
        gnt_next   = '0;
        state_next = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (!spi_busy)
          state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (arb_found) begin
          gnt_next   = NUM_REQ'(1) << arb_idx;
          last_next  = arb_idx;
          state_next = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!owner_req || to_hit) begin
          gnt_next         = '0;
          drain_first_next = 1'b1;
          err_seen_next    = 1'b0;
          state_next       = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A core error seen at any point of the drain forces a fresh core reset.
        err_seen_next = err_seen_reg | spi_err;
        if (drain_first_reg)
          drain_first_next = 1'b0;
        else if (!spi_busy)
          state_next = (err_seen_reg | spi_err) ? ST_INIT : ST_IDLE;
      end
      default: begin
        gnt_next   = '0;
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg       <= ST_INIT;
      gnt_reg         <= '0;
      last_reg        <= IW'(NUM_REQ - 1);
      drain_first_reg <= 1'b0;
      err_seen_reg    <= 1'b0;
      spi_rst_reg     <= 1'b0;
      addr_reg        <= '0;
      speed_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      last_reg        <= last_next;
      drain_first_reg <= drain_first_next;
      err_seen_reg    <= err_seen_next;
      spi_rst_reg     <= (state_reg == ST_INIT);
      if (in_owned) begin
        addr_reg  <= owner_addr;
        speed_reg <= owner_speed;
      end
    end
  end

endmodule
